// File: rtl/baud_tick_ctrl.sv
// baud_tick_ctrl: runtime-configurable UART sample/bit tick generator with shadowed divisor
module baud_tick_ctrl #(
  parameter int N           = 10,
  parameter int DEFAULT_DIV = 651,
  parameter int OS          = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         div_wr,
  input  logic [N-1:0] div_in,
  input  logic         phase_sync,
  output logic         s_tick,
  output logic         b_tick,
  output logic [N-1:0] div_cur,
  output logic         div_pend,
  output logic         div_err
);
  localparam int OW = $clog2(OS);
  localparam logic [N-1:0] ONE = N'(1);
  localparam logic [N-1:0] TWO = N'(2);
  localparam logic [N-1:0] DEF = N'(DEFAULT_DIV);
  logic [N-1:0] cnt, cur, pend;
  logic [OW-1:0] os_cnt;
  logic pend_v, err, wr_ok, apply;
  // A pending divisor lands only on a period boundary, so cnt restarts with it
  always_comb begin
    s_tick = en && !phase_sync && (cnt == cur - ONE);
    b_tick = s_tick && (os_cnt == OW'(OS - 1));
    wr_ok  = div_wr && (div_in >= TWO);
    apply  = pend_v && (s_tick || !en || phase_sync);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      os_cnt <= '0;
      cur    <= DEF;
      pend   <= DEF;
      pend_v <= 1'b0;
      err    <= 1'b0;
    end else begin
      err    <= div_wr && !wr_ok;
      cur    <= apply ? pend : cur;
      pend   <= wr_ok ? div_in : pend;
      pend_v <= wr_ok || (pend_v && !apply);
      cnt    <= (phase_sync || apply || s_tick) ? '0 : en ? cnt + ONE : cnt;
      os_cnt <= (phase_sync || b_tick) ? '0 : s_tick ? os_cnt + OW'(1) : os_cnt;
    end
  end
  assign div_cur  = cur;
  assign div_pend = pend_v;
  assign div_err  = err;
endmodule
